alu_result_packer: RTL
======================

Name: alu_result_packer

Overview:
- Downstream of the ALU signed multiplier: accepts each 2N-bit product and emits it as two N-bit words over a valid/ready stream toward the register file / TX path.
- A small internal FIFO absorbs bursts of products while the consumer stalls.
- Flags any product that arrives while the FIFO is full.

Parameters:
- N, 8, operand width; product is 2N bits, output word is N bits.
- DEPTH, 4, FIFO depth in products; power of two, >= 2.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- in_valid  input  1  product on in_data is valid this cycle.
- in_data  input  2N  signed product, two's complement.
- in_ready  output  1  FIFO can accept a product this cycle.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  N  current output word.
- out_last  output  1  high on the second word of a product.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- ovf_err  output  1  sticky: a product was dropped.
- fill  output  log2(DEPTH)+1  number of products stored.

Behaviour:
- Reset (RST=1 at a clock edge) takes effect on that edge and overrides all other activity, including mid-product:
  - FIFO emptied: wr_ptr = rd_ptr = 0, fill = 0.
  - FSM goes to IDLE.
  - Outputs: out_valid = 0, out_last = 0, ovf_err = 0, out_data = 0.
  - A partially sent product is discarded.
- Push: in_ready = (fill != DEPTH). A write occurs when in_valid && in_ready; data is stored at wr_ptr, and wr_ptr wraps modulo DEPTH.
- Drop: in_valid && !in_ready discards the product and sets ovf_err. ovf_err clears only on reset.
- FSM states:
  - IDLE: fill == 0. out_valid = 0. Goes to LO the cycle after the first push.
  - LO: out_valid = 1, out_data = head[N-1:0], out_last = 0. On handshake, goes to HI.
  - HI: out_valid = 1, out_data = head[2N-1:N], out_last = 1. On handshake:
    - the head is popped and rd_ptr wraps modulo DEPTH;
    - next state is LO if fill after the pop is > 0, else IDLE.
- Latency: a product pushed at edge k is visible on the output from cycle k+1 when the FIFO was empty. No combinational in→out bypass.
- Stall: while out_valid && !out_ready, out_data, out_last and state hold stable.
- Simultaneous push and pop in the same cycle (HI handshake): fill is unchanged and both pointers advance.
- When full, in_ready = 0 even if a pop occurs that cycle. No same-cycle refill.
- fill is a registered count, incremented on push and decremented on pop.
- No sign or width manipulation; the bit pattern of the product is preserved exactly.

Optional Feature:
- Macro ALU_PACK_MSB_FIRST_EN.
- Defined: LO state sends head[2N-1:N] and HI state sends head[N-1:0]; out_last still marks the second word.
- Undefined (default): low half first, as described in Behaviour.

Test Plan:
- Reset hold: RST=1 for 2 cycles with in_valid=1, in_data=16'h1234 -> out_valid=0, fill=0, ovf_err=0. Nothing is stored.
- Single product: push 16'hFFF4 (-12) with out_ready=1 -> out_data 8'hF4 (out_last=0) next cycle, then 8'hFF (out_last=1), then out_valid=0.
- Backpressure: push 16'h0102 with out_ready=0 for 5 cycles -> out_data stays 8'h02 with out_valid=1. Releasing out_ready then yields 8'h02, 8'h01.
- Fill and overflow (DEPTH=4): out_ready=0, push 5 products 16'h0001..16'h0005 on consecutive cycles -> in_ready=0 after the 4th, the 5th is dropped, ovf_err=1, fill=4. Draining emits 01,00,02,00,03,00,04,00.
- Push during pop: fill=2, product 16'hAA55 pushed in the same cycle as the HI handshake -> fill stays 2, both pointers advance. 16'hAA55 later emits 55, AA in order.
- Reset mid-product: after the LO word of 16'hBEEF (EF) is accepted, assert RST -> next cycle out_valid=0, fill=0. The BE word is never emitted.

Source files
------------

// File: rtl/alu_result_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_packer_if
// Brief    : Product-in / word-out stream bundle for alu_result_packer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_result_packer_if #(
    parameter int N     = 8,
    parameter int DEPTH = 4
);
    localparam int c_fill_w = $clog2(DEPTH) + 1;

    logic                in_valid;
    logic [2*N-1:0]      in_data;
    logic                in_ready;
    logic                out_valid;
    logic [N-1:0]        out_data;
    logic                out_last;
    logic                out_ready;
    logic                ovf_err;
    logic [c_fill_w-1:0] fill;

    // Producer of products / consumer of words (testbench or surrounding logic).
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, ovf_err, fill
    );

    // The packer itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, ovf_err, fill
    );
endinterface
`default_nettype wire

// File: rtl/alu_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_packer
// Brief    : Buffers 2N-bit signed products in a small FIFO and emits each as
//            two N-bit words on a valid/ready stream. Define
//            ALU_PACK_MSB_FIRST_EN to send the upper half first.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_packer #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    alu_result_packer_if.slave bus
);
    localparam int c_aw     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_fill_w = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [c_aw-1:0]       wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]       rd_ptr_q, rd_ptr_d;
    logic [c_fill_w-1:0]   fill_q, fill_d;
    logic                  ovf_q, ovf_d;
    logic [2*N-1:0]        mem_q [DEPTH];

    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;
    logic [2*N-1:0]        w_head;
    logic [N-1:0]          w_first_word;
    logic [N-1:0]          w_second_word;

    assign w_head = mem_q[rd_ptr_q];

`ifdef ALU_PACK_MSB_FIRST_EN
    assign w_first_word  = w_head[2*N-1:N];
    assign w_second_word = w_head[N-1:0];
`else
    assign w_first_word  = w_head[N-1:0];
    assign w_second_word = w_head[2*N-1:N];
`endif

    // Full blocks writes even when the head is popped this cycle.
    assign w_in_ready = (fill_q != c_fill_w'(DEPTH));
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = (state_q == ST_HI) && bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        ovf_d    = ovf_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_aw'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_aw'(1);
        end

        case ({w_push, w_pop})
            2'b10:   fill_d = fill_q + c_fill_w'(1);
            2'b01:   fill_d = fill_q - c_fill_w'(1);
            default: fill_d = fill_q;
        endcase

        if (bus.in_valid && !w_in_ready) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_push) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                bus.out_valid = 1'b1;
                bus.out_data  = w_first_word;
                if (bus.out_ready) begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                bus.out_valid = 1'b1;
                bus.out_data  = w_second_word;
                bus.out_last  = 1'b1;
                if (bus.out_ready) begin
                    state_d = (fill_d != '0) ? ST_LO : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: pointers and fill define what is valid.
    always_ff @(posedge CLK) begin
        if (!RST && w_push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.ovf_err  = ovf_q;
    assign bus.fill     = fill_q;

endmodule
`default_nettype wire
